// File: rtl/skin_bbox_detect.sv
// skin_bbox_detect
//   YCbCr skin-colour binarizer with per-frame bounding-box statistics.
//   Each pixel is classified as skin by inclusive Cb/Cr range checks. The
//   classification is registered to out_bin. The syncs are delayed by the
//   same single cycle. Skin pixels that are active and outside vsync are
//   folded into min/max/count accumulators. These accumulators are reported
//   and then cleared on every vsync rising edge, starting with the second
//   edge after reset.
//
// Ports
//   clk, nrst                 clock (rising edge), async active-low reset
//   in_y, in_cb, in_cr        pixel components (in_y is not used)
//   in_hsync, in_vsync, in_en line sync, frame sync, active-pixel qualifier
//   out_bin                   8'hFF skin / 8'h00 non-skin, 1-cycle latency
//   out_hsync/vsync/en        input syncs delayed 1 cycle
//   box_valid                 1-cycle pulse when box_* / skin_cnt update
//   box_found                 last reported frame contained skin
//   box_xmin..box_ymax        bounding box of skin in last reported frame
//   skin_cnt                  saturating skin pixel count of that frame
module skin_bbox_detect #(
    parameter logic [7:0] CB_MIN = 8'd77,
    parameter logic [7:0] CB_MAX = 8'd127,
    parameter logic [7:0] CR_MIN = 8'd133,
    parameter logic [7:0] CR_MAX = 8'd173
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  in_y,
    input  logic [7:0]  in_cb,
    input  logic [7:0]  in_cr,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_en,
    output logic [7:0]  out_bin,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_en,
    output logic        box_valid,
    output logic        box_found,
    output logic [10:0] box_xmin,
    output logic [10:0] box_xmax,
    output logic [10:0] box_ymin,
    output logic [10:0] box_ymax,
    output logic [21:0] skin_cnt
);

    typedef enum logic {UNARMED, ARMED} state_t;

    state_t      state;
    logic [10:0] col;
    logic [10:0] row;
    logic [10:0] acc_xmin;
    logic [10:0] acc_xmax;
    logic [10:0] acc_ymin;
    logic [10:0] acc_ymax;
    logic [21:0] acc_cnt;
    logic        acc_any;

    logic is_skin;
    logic vs_rise;
    logic en_fall;
    logic count_px;
    logic unused_y;

    assign unused_y = ^in_y;

    assign is_skin  = (in_cb >= CB_MIN) && (in_cb <= CB_MAX) &&
                      (in_cr >= CR_MIN) && (in_cr <= CR_MAX);
    // out_vsync / out_en already hold the previous-cycle input values,
    // so they double as the edge-detect history registers.
    assign vs_rise  = in_vsync & ~out_vsync;
    assign en_fall  = out_en & ~in_en;
    assign count_px = in_en & ~in_vsync & is_skin;

    // Binarized output and aligned syncs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_bin   <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_en    <= 1'b0;
        end else begin
            out_bin   <= (in_en && is_skin) ? 8'hFF : 8'h00;
            out_hsync <= in_hsync;
            out_vsync <= in_vsync;
            out_en    <= in_en;
        end
    end

    // Column / row position of the pixel currently on the inputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            col <= '0;
            row <= '0;
        end else begin
            if (!in_en)
                col <= '0;
            else if (col != 11'h7FF)
                col <= col + 11'd1;

            if (vs_rise)
                row <= '0;
            else if (en_fall && row != 11'h7FF)
                row <= row + 11'd1;
        end
    end

    // Arming FSM, accumulators and frame report
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= UNARMED;
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
            acc_cnt   <= '0;
            acc_any   <= 1'b0;
            box_valid <= 1'b0;
            box_found <= 1'b0;
            box_xmin  <= '0;
            box_xmax  <= '0;
            box_ymin  <= '0;
            box_ymax  <= '0;
            skin_cnt  <= '0;
        end else begin
            box_valid <= 1'b0;
            if (vs_rise) begin
                if (state == ARMED) begin
                    box_valid <= 1'b1;
                    box_found <= acc_any;
                    box_xmin  <= acc_any ? acc_xmin : '0;
                    box_xmax  <= acc_any ? acc_xmax : '0;
                    box_ymin  <= acc_any ? acc_ymin : '0;
                    box_ymax  <= acc_any ? acc_ymax : '0;
                    skin_cnt  <= acc_any ? acc_cnt  : '0;
                end
                state    <= ARMED;
                acc_xmin <= '1;
                acc_xmax <= '0;
                acc_ymin <= '1;
                acc_ymax <= '0;
                acc_cnt  <= '0;
                acc_any  <= 1'b0;
            end else if (count_px) begin
                acc_any <= 1'b1;
                if (col < acc_xmin) acc_xmin <= col;
                if (col > acc_xmax) acc_xmax <= col;
                if (row < acc_ymin) acc_ymin <= row;
                if (row > acc_ymax) acc_ymax <= row;
                if (acc_cnt != '1) acc_cnt <= acc_cnt + 22'd1;
            end
        end
    end

endmodule

// File: tb/tb_skin_bbox_detect.sv
// tb_skin_bbox_detect
//   Directed stimulus for skin_bbox_detect. Every driven cycle pushes its
//   expected pipeline outputs to a queue. Every frame report is pushed to a
//   second queue at the vsync edge that should produce it. Both queues are
//   popped and compared after the clock edge. Explicit constant checks
//   cover the headline frame cases.
module tb_skin_bbox_detect;

    localparam logic [7:0] CB_MIN = 8'd77;
    localparam logic [7:0] CB_MAX = 8'd127;
    localparam logic [7:0] CR_MIN = 8'd133;
    localparam logic [7:0] CR_MAX = 8'd173;

    logic        clk;
    logic        nrst;
    logic [7:0]  in_y, in_cb, in_cr;
    logic        in_hsync, in_vsync, in_en;
    logic [7:0]  out_bin;
    logic        out_hsync, out_vsync, out_en;
    logic        box_valid, box_found;
    logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic [21:0] skin_cnt;

    skin_bbox_detect #(
        .CB_MIN(CB_MIN), .CB_MAX(CB_MAX), .CR_MIN(CR_MIN), .CR_MAX(CR_MAX)
    ) dut (
        .clk(clk), .nrst(nrst),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_en(in_en),
        .out_bin(out_bin), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_en(out_en),
        .box_valid(box_valid), .box_found(box_found),
        .box_xmin(box_xmin), .box_xmax(box_xmax),
        .box_ymin(box_ymin), .box_ymax(box_ymax),
        .skin_cnt(skin_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bin;
        logic       hs, vs, en;
    } pipe_t;

    typedef struct packed {
        logic        found;
        logic [10:0] xmin, xmax, ymin, ymax;
        logic [21:0] cnt;
    } rpt_t;

    pipe_t pipe_q[$];
    rpt_t  rpt_q[$];

    int unsigned total_cnt  = 0;
    int unsigned passed_cnt = 0;

    // Reference model state
    logic        armed;
    logic        m_vs_prev, m_en_prev;
    logic [10:0] m_col, m_row;
    logic [10:0] m_xmin, m_xmax, m_ymin, m_ymax;
    logic [21:0] m_cnt;
    logic        m_any;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_xmin = 11'h7FF; m_xmax = '0; m_ymin = 11'h7FF; m_ymax = '0;
        m_cnt = '0; m_any = 1'b0;
    endtask

    task automatic model_reset();
        armed = 1'b0; m_vs_prev = 1'b0; m_en_prev = 1'b0;
        m_col = '0; m_row = '0;
        model_clear();
        pipe_q.delete();
        rpt_q.delete();
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic step(input logic [7:0] cb, input logic [7:0] cr,
                        input logic hs, input logic vs, input logic en);
        logic  skin, rise, exp_valid;
        pipe_t p, g;
        rpt_t  r, e;
        in_cb = cb; in_cr = cr; in_y = cb ^ 8'h5A;
        in_hsync = hs; in_vsync = vs; in_en = en;

        skin = (cb >= CB_MIN) && (cb <= CB_MAX) && (cr >= CR_MIN) && (cr <= CR_MAX);
        p.bin = (en && skin) ? 8'hFF : 8'h00;
        p.hs = hs; p.vs = vs; p.en = en;
        pipe_q.push_back(p);

        rise = vs && !m_vs_prev;
        exp_valid = 1'b0;
        if (rise) begin
            if (armed) begin
                r.found = m_any;
                r.xmin = m_any ? m_xmin : '0;
                r.xmax = m_any ? m_xmax : '0;
                r.ymin = m_any ? m_ymin : '0;
                r.ymax = m_any ? m_ymax : '0;
                r.cnt  = m_any ? m_cnt  : '0;
                rpt_q.push_back(r);
                exp_valid = 1'b1;
            end
            armed = 1'b1;
            model_clear();
        end else if (en && !vs && skin) begin
            m_any = 1'b1;
            if (m_col < m_xmin) m_xmin = m_col;
            if (m_col > m_xmax) m_xmax = m_col;
            if (m_row < m_ymin) m_ymin = m_row;
            if (m_row > m_ymax) m_ymax = m_row;
            if (m_cnt != 22'h3FFFFF) m_cnt = m_cnt + 22'd1;
        end
        if (rise) m_row = '0;
        else if (m_en_prev && !en && m_row != 11'h7FF) m_row = m_row + 11'd1;
        if (!en) m_col = '0;
        else if (m_col != 11'h7FF) m_col = m_col + 11'd1;
        m_en_prev = en;
        m_vs_prev = vs;

        @(posedge clk);
        #1;
        g = pipe_q.pop_front();
        check("out_bin", {24'd0, out_bin}, {24'd0, g.bin});
        check("out_hsync", {31'd0, out_hsync}, {31'd0, g.hs});
        check("out_vsync", {31'd0, out_vsync}, {31'd0, g.vs});
        check("out_en", {31'd0, out_en}, {31'd0, g.en});
        check("box_valid", {31'd0, box_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            e = rpt_q.pop_front();
            check("box_found", {31'd0, box_found}, {31'd0, e.found});
            check("box_xmin", {21'd0, box_xmin}, {21'd0, e.xmin});
            check("box_xmax", {21'd0, box_xmax}, {21'd0, e.xmax});
            check("box_ymin", {21'd0, box_ymin}, {21'd0, e.ymin});
            check("box_ymax", {21'd0, box_ymax}, {21'd0, e.ymax});
            check("skin_cnt", {10'd0, skin_cnt}, {10'd0, e.cnt});
        end
    endtask

    // Two vsync cycles (optionally with active skin pixels), then idle.
    task automatic vsync_pulse(input logic skin_in_vs);
        step(8'd100, 8'd150, 1'b0, 1'b1, skin_in_vs);
        step(8'd100, 8'd150, 1'b0, 1'b1, skin_in_vs);
        step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // mode 0: no skin, 1: skin at (2,1) and (5,3), 2: all skin
    task automatic frame(input int unsigned w, input int unsigned h,
                         input int unsigned mode);
        logic s;
        for (int unsigned r = 0; r < h; r++) begin
            for (int unsigned c = 0; c < w; c++) begin
                s = (mode == 2) || (mode == 1 && ((c == 2 && r == 1) || (c == 5 && r == 3)));
                if (s) step(8'd100, 8'd150, 1'b0, 1'b0, 1'b1);
                else   step(8'd30, 8'd200, 1'b0, 1'b0, 1'b1);
            end
            step(8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
            step(8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bin"}, {24'd0, out_bin}, 32'd0);
        check({tag, "_syncs"}, {29'd0, out_hsync, out_vsync, out_en}, 32'd0);
        check({tag, "_valid_found"}, {30'd0, box_valid, box_found}, 32'd0);
        check({tag, "_x"}, {10'd0, box_xmin, box_xmax}, 32'd0);
        check({tag, "_y"}, {10'd0, box_ymin, box_ymax}, 32'd0);
        check({tag, "_cnt"}, {10'd0, skin_cnt}, 32'd0);
    endtask

    initial begin
        nrst = 1'b0;
        in_y = '0; in_cb = '0; in_cr = '0;
        in_hsync = 1'b0; in_vsync = 1'b0; in_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        nrst = 1'b1;

        // Classification boundaries
        step(8'd77,  8'd133, 1'b0, 1'b0, 1'b1);
        step(8'd76,  8'd133, 1'b0, 1'b0, 1'b1);
        step(8'd127, 8'd174, 1'b0, 1'b0, 1'b1);
        step(8'd127, 8'd173, 1'b0, 1'b0, 1'b1);
        step(8'd128, 8'd150, 1'b0, 1'b0, 1'b1);
        step(8'd100, 8'd132, 1'b0, 1'b0, 1'b1);
        step(8'd100, 8'd150, 1'b1, 1'b0, 1'b0);

        // Arm, then an 8x4 frame with two skin pixels
        vsync_pulse(1'b0);
        frame(8, 4, 1);
        vsync_pulse(1'b1);
        check("f1_xmin", {21'd0, box_xmin}, 32'd2);
        check("f1_xmax", {21'd0, box_xmax}, 32'd5);
        check("f1_ymin", {21'd0, box_ymin}, 32'd1);
        check("f1_ymax", {21'd0, box_ymax}, 32'd3);
        check("f1_cnt_found", {9'd0, box_found, skin_cnt}, {9'd0, 1'b1, 22'd2});
        repeat (3) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check("f1_hold_xmax", {21'd0, box_xmax}, 32'd5);

        // No-skin frame; skin pixels active during the previous vsync must not count
        frame(8, 4, 0);
        vsync_pulse(1'b0);
        check("f2_found", {31'd0, box_found}, 32'd0);
        check("f2_box", {box_xmin, box_xmax, box_ymin[9:0]}, 32'd0);
        check("f2_cnt", {10'd0, skin_cnt}, 32'd0);

        // Reset in the middle of a skin frame
        frame(8, 2, 2);
        step(8'd100, 8'd150, 1'b0, 1'b0, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(posedge clk);
        #1;
        model_reset();
        nrst = 1'b1;
        vsync_pulse(1'b0);
        frame(8, 4, 1);
        vsync_pulse(1'b0);
        check("f3_box", {box_xmin, box_xmax, box_ymin[9:0]}, {11'd2, 11'd5, 10'd1});
        check("f3_cnt", {10'd0, skin_cnt}, 32'd2);

        // Long line: column counter saturates
        frame(2100, 1, 2);
        vsync_pulse(1'b0);
        check("f4_xmax", {21'd0, box_xmax}, 32'd2047);
        check("f4_cnt", {10'd0, skin_cnt}, 32'd2100);
        check("f4_xmin_y", {box_xmin, box_ymin, box_ymax[9:0]}, 32'd0);

        check("rpt_queue_empty", rpt_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
